// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block and the PWM generator side.
package pwm_pkg;

   localparam int W_DEF           = 8;
   localparam int CNT_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int TIMEOUT_DEF     = 512;

   // Nominal PWM period in clocks for the default sample width.
   localparam int FULL_PERIOD = 1 << W_DEF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      STUCK   = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer chain for the asynchronous PWM line plus rising-edge detect.
// s_o is the synchronized level; rise_o is high for the one cycle in which
// s_o is 1 and its one-cycle-delayed copy is still 0.
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pwm_i,
   output logic s_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;

   // Shift the raw line through the synchronizer, then keep one delayed copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
         s_d_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input between
// successive rising edges, and flags a line stuck high or low.
//
// Output strobe: valid is a one-cycle pulse with no back-pressure; in the
// cycle valid is high, high_cnt, period_cnt, duty, period_err and the stuck
// flags all hold the freshly updated result. There is no ready; a consumer
// that misses the pulse misses the sample.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int W           = W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic [W-1:0]     duty,
   output logic             valid,
   output logic             period_err,
   output logic             stuck_hi,
   output logic             stuck_lo,
   output state_t           state_dbg
);

   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_P_C   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(1 << W);
   localparam logic [CNT_W-1:0] DUTY_MAX_C = CNT_W'((1 << W) - 1);

   logic s;
   logic rise;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] p_q, p_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [W-1:0]     duty_q, duty_d;
   logic             valid_q, valid_d;
   logic             period_err_q, period_err_d;
   logic             stuck_hi_q, stuck_hi_d;
   logic             stuck_lo_q, stuck_lo_d;
   logic             enter_stuck;

   pwm_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .pwm_i  (pwm_in),
      .s_o    (s),
      .rise_o (rise)
   );

   // State, counters and result registers; everything clears on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         p_q          <= '0;
         h_q          <= '0;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         duty_q       <= '0;
         valid_q      <= 1'b0;
         period_err_q <= 1'b0;
         stuck_hi_q   <= 1'b0;
         stuck_lo_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         h_q          <= h_d;
         high_cnt_q   <= high_cnt_d;
         period_cnt_q <= period_cnt_d;
         duty_q       <= duty_d;
         valid_q      <= valid_d;
         period_err_q <= period_err_d;
         stuck_hi_q   <= stuck_hi_d;
         stuck_lo_q   <= stuck_lo_d;
      end
   end

   // Next-state logic: a rise always beats a timeout in the same cycle,
   // and en low beats everything.
   always_comb begin
      state_d      = state_q;
      p_d          = p_q;
      h_d          = h_q;
      high_cnt_d   = high_cnt_q;
      period_cnt_d = period_cnt_q;
      duty_d       = duty_q;
      valid_d      = 1'b0;
      period_err_d = period_err_q;
      stuck_hi_d   = stuck_hi_q;
      stuck_lo_d   = stuck_lo_q;
      enter_stuck  = 1'b0;

      if (!en) begin
         state_d    = IDLE;
         p_d        = '0;
         h_d        = '0;
         stuck_hi_d = 1'b0;
         stuck_lo_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  p_d     = ONE_C;
                  h_d     = ONE_C;
                  state_d = MEASURE;
               end else if (p_q == LAST_P_C) begin
                  enter_stuck = 1'b1;
               end else begin
                  p_d = p_q + ONE_C;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_cnt_d = p_q;
                  high_cnt_d   = h_q;
                  duty_d       = (h_q > DUTY_MAX_C) ? {W{1'b1}} : h_q[W-1:0];
                  period_err_d = (p_q != FULL_C);
                  stuck_hi_d   = 1'b0;
                  stuck_lo_d   = 1'b0;
                  valid_d      = 1'b1;
                  p_d          = ONE_C;
                  h_d          = ONE_C;
               end else if (p_q == LAST_P_C) begin
                  enter_stuck = 1'b1;
               end else begin
                  p_d = p_q + ONE_C;
                  h_d = h_q + CNT_W'(s);
               end
            end
            STUCK: begin
               // Counters hold here; recovery restarts a fresh measurement.
               if (rise) begin
                  stuck_hi_d = 1'b0;
                  stuck_lo_d = 1'b0;
                  p_d        = ONE_C;
                  h_d        = ONE_C;
                  state_d    = MEASURE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (enter_stuck) begin
            state_d      = STUCK;
            stuck_hi_d   = s;
            stuck_lo_d   = ~s;
            duty_d       = s ? {W{1'b1}} : '0;
            high_cnt_d   = s ? TIMEOUT_C : '0;
            period_cnt_d = TIMEOUT_C;
            period_err_d = 1'b1;
            valid_d      = 1'b1;
         end
      end
   end

   assign high_cnt   = high_cnt_q;
   assign period_cnt = period_cnt_q;
   assign duty       = duty_q;
   assign valid      = valid_q;
   assign period_err = period_err_q;
   assign stuck_hi   = stuck_hi_q;
   assign stuck_lo   = stuck_lo_q;
   assign state_dbg  = state_q;

endmodule
